// File: rtl/sparse_idx_pkg.sv
// Shared defaults, LFSR constants and FSM encoding for the sparse index loader.
package sparse_idx_pkg;

   localparam int unsigned IDX_WIDTH_DEF = 16;
   localparam int unsigned NUM_IDX_DEF   = 8;
   localparam int unsigned POLY_N_DEF    = 17669;

   // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sparse_idx_lfsr.sv
// 16-bit Fibonacci LFSR used to decide and generate dummy indices.
// A zero seed is replaced by the default seed so the register never locks up.
module sparse_idx_lfsr
   import sparse_idx_pkg::*;
(
   input  logic        clk,
   input  logic        reset_i,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   logic [15:0] state_q, state_d;

   // Reseed on load, otherwise shift once per step
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == '0) ? LFSR_SEED_DEF : seed;
      end else if (step) begin
         state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
      end
   end

   // State register, reset to the default seed
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) state_q <= LFSR_SEED_DEF;
      else         state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/sparse_idx_loader.sv
// Sparse index loader: latches a packed key, range-checks it, then streams the
// indices to a downstream multiplier over a valid/ready handshake.
// Optional feature: define DUMMY_INSERT_EN to insert LFSR-driven dummy indices
// (at most one before each real index).
module sparse_idx_loader
   import sparse_idx_pkg::*;
#(
   parameter int unsigned pIDX_WIDTH = IDX_WIDTH_DEF,
   parameter int unsigned pNUM_IDX   = NUM_IDX_DEF,
   parameter int unsigned pPOLY_N    = POLY_N_DEF
) (
   input  logic                           clk,
   input  logic                           reset_i,
   input  logic                           load_i,
   input  logic [pNUM_IDX*pIDX_WIDTH-1:0] key_i,
   input  logic [15:0]                    seed_i,
   output logic [pIDX_WIDTH-1:0]          idx_o,
   output logic                           idx_valid_o,
   output logic                           idx_dummy_o,
   input  logic                           idx_ready_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           err_o
);

   localparam int unsigned     CNT_W    = (pNUM_IDX > 1) ? $clog2(pNUM_IDX) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(pNUM_IDX - 1);

   state_e                         state_q, state_d;
   logic [pNUM_IDX*pIDX_WIDTH-1:0] key_q, key_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           err_q, err_d;
   logic                           load_acc, range_err, xfer, cur_dummy, last_real;
   logic [pIDX_WIDTH-1:0]          real_idx, dummy_idx;

   assign load_acc  = (state_q == ST_IDLE) && load_i;
   assign xfer      = (state_q == ST_EMIT) && idx_ready_i;
   assign real_idx  = key_q[cnt_q*pIDX_WIDTH +: pIDX_WIDTH];
   assign last_real = xfer && !cur_dummy && (cnt_q == LAST_CNT);

   // Flag any incoming index outside 0..pPOLY_N-1
   always_comb begin
      range_err = 1'b0;
      for (int unsigned k = 0; k < pNUM_IDX; k++) begin
         if (32'(key_i[k*pIDX_WIDTH +: pIDX_WIDTH]) >= pPOLY_N) range_err = 1'b1;
      end
   end

`ifdef DUMMY_INSERT_EN
   logic [15:0] lfsr_state;
   logic [31:0] dummy_raw;
   logic        dmy_done_q, dmy_done_d;
   logic        unused_lfsr;

   sparse_idx_lfsr u_lfsr (
      .clk     (clk),
      .reset_i (reset_i),
      .load    (load_acc),
      .seed    (seed_i),
      .step    (xfer),
      .state   (lfsr_state)
   );

   assign dummy_raw   = {17'd0, lfsr_state[14:0]};
   assign unused_lfsr = lfsr_state[15];

   // The dummy decision for a real index is made once; after a dummy the real
   // index follows unconditionally, which caps dummies at one per index.
   assign cur_dummy = (state_q == ST_EMIT) && !dmy_done_q && lfsr_state[0];

   // Fold dummy values at or above pPOLY_N back into range
   always_comb begin
      dummy_idx = pIDX_WIDTH'(dummy_raw);
      if (dummy_raw >= pPOLY_N) dummy_idx = pIDX_WIDTH'(dummy_raw - pPOLY_N);
   end

   // Track whether the pending real index has already had its dummy
   always_comb begin
      dmy_done_d = dmy_done_q;
      if (load_acc)  dmy_done_d = 1'b0;
      else if (xfer) dmy_done_d = cur_dummy;
   end

   // Dummy-tracking register
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) dmy_done_q <= 1'b0;
      else         dmy_done_q <= dmy_done_d;
   end
`else
   logic unused_seed;

   assign cur_dummy   = 1'b0;
   assign dummy_idx   = '0;
   assign unused_seed = ^seed_i;
`endif

   // Datapath next-state: latch key on accepted load, advance on real transfers
   always_comb begin
      key_d = key_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (load_acc) begin
         key_d = key_i;
         cnt_d = '0;
         err_d = range_err;
      end else if (xfer && !cur_dummy && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         key_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         key_q <= key_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: a range error skips emission and goes straight to DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (load_i) state_d = range_err ? ST_DONE : ST_EMIT;
         ST_EMIT: if (last_real) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; idx_o only changes on a transfer, so it holds during stalls
   always_comb begin
      idx_o       = '0;
      idx_valid_o = 1'b0;
      idx_dummy_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         ST_EMIT: begin
            idx_valid_o = 1'b1;
            idx_dummy_o = cur_dummy;
            idx_o       = cur_dummy ? dummy_idx : real_idx;
            busy_o      = 1'b1;
         end
         ST_DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign err_o = err_q;

endmodule
